cdc_hs_src: RTL and testbench
=============================

Name: cdc_hs_src

Overview:
- Source-side transmitter of a toggle-based req/ack bundled-data clock-domain crossing.
- Accepts a word in the clk domain, holds it stable on xdata and toggles xreq.
- The far domain detects the toggle with its double-flop synchronizer, samples xdata, then returns the toggle on xack.
- This block resynchronizes xack internally and frees itself for the next word; it is the launching end of the same crossing that the p_SSYNC-style synchronizers terminate.

Parameters:
- WIDTH, 32, data width of src_data/xdata.
- SYNC_STAGES, 2, flops in the xack synchronizer chain (legal 2..4).

Ports:
- clk  input  1  source-domain clock.
- clr_  input  1  reset, asynchronous, active-low.
- src_vld  input  1  source offers src_data.
- src_rdy  output  1  block can accept; transfer occurs when src_vld && src_rdy at posedge clk.
- src_data  input  WIDTH  word to send.
- xreq  output  1  request toggle level to the far domain; registered, glitch-free.
- xdata  output  WIDTH  bundled data, registered, stable while a request is outstanding.
- xack  input  1  acknowledge toggle level from the far domain; asynchronous to clk.
- busy  output  1  request outstanding (state WAIT).
- err  output  1  sticky protocol error.

Behaviour:
- Reset (clr_ low, async) forces:
  - xreq=0, xdata=0, all xack sync flops=0, state=IDLE.
  - src_rdy=0, busy=0, err=0.
- First posedge after clr_ rises sets src_rdy=1, so src_rdy is registered and never combinational from inputs.
- ack_s is the last stage of the SYNC_STAGES-flop chain on xack; every stage resets to 0.
- IDLE state:
  - src_rdy=1, busy=0.
  - On src_vld && src_rdy: at the same edge, xdata<=src_data and xreq<=~xreq, state->WAIT, src_rdy<=0, busy<=1.
  - Latency from accepting edge to xreq/xdata change is 0 cycles; both update on the accepting edge.
  - xdata and xreq leave from the same edge. Validity relies on the receiver sampling xdata only after its own req synchronizer.
- WAIT state:
  - src_rdy=0; src_data is ignored.
  - When ack_s==xreq: state->IDLE, busy<=0, src_rdy<=1 at that edge.
  - A new word can be accepted no earlier than the following edge.
- Minimum source-side occupancy per word: 1 accept edge + SYNC_STAGES edges after the xack toggle + 1 edge to return to IDLE.
- xdata holds its value in IDLE and WAIT and changes only on an accepting edge.
- Protocol error: in IDLE with ack_s != xreq, an ack toggle arrived with no outstanding request.
  - err<=1, held sticky until clr_.
  - State is unchanged; src_rdy stays 1.
- Simultaneous events:
  - src_vld high on the edge where WAIT->IDLE is taken is not accepted; src_rdy is 0 in that cycle.
  - No combinational path exists from xack to any output.
- Reset mid-transfer: all state clears and xreq returns to 0. The far end must be reset in the same reset domain; no recovery handshake is defined.
- xreq is driven directly from a flop with no logic after the register.

Test Plan:
- Reset release: clr_ low for 3 cycles then high -> during reset xreq=0, xdata=0, src_rdy=0; src_rdy=1 on the first edge after release; err=0.
- Single transfer, SYNC_STAGES=2:
  - Stimulus: src_data=32'hA5A5_0001, src_vld=1 for one cycle; bench toggles xack 0->1 four cycles after xreq rises.
  - Required: xreq 0->1 and xdata=32'hA5A5_0001 on the accepting edge; busy=1.
  - Required: src_rdy returns to 1 exactly 2 edges after the xack toggle is first sampled.
- Back-to-back words:
  - Stimulus: src_vld held high with data 1, 2, 3; bench echoes xreq to xack after 3 cycles each.
  - Required: xreq toggles 1, 0, 1; xdata goes 1, 2, 3; each word is held constant until its ack; no word is dropped or duplicated.
- Stall while pending: src_data changes every cycle during WAIT -> xdata unchanged, src_rdy=0, xreq unchanged.
- Spurious ack: in IDLE with xreq=0, bench drives xack=1 -> err=1 after SYNC_STAGES+1 edges, remains 1; a subsequent normal transfer still completes.
- Reset mid-transfer: assert clr_ while busy=1 with xreq=1 -> xreq, busy and xdata go to 0 immediately (async); after release a new transfer toggles xreq 0->1.

Source files
------------

// File: rtl/cdc_hs_src.sv
// Source-side launcher of a toggle req/ack bundled-data clock-domain crossing.
// A word accepted in the clk domain is parked on xdata while xreq toggles; the
// block stays busy until the far side echoes the toggle back on xack.
module cdc_hs_src #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic             src_vld,
    output logic             src_rdy,
    input  logic [WIDTH-1:0] src_data,
    output logic             xreq,
    output logic [WIDTH-1:0] xdata,
    input  logic             xack,
    output logic             busy,
    output logic             err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   xreq_nxt;
    logic [WIDTH-1:0]       xdata_nxt;
    logic                   src_rdy_nxt;
    logic                   busy_nxt;
    logic                   err_nxt;

    // Multi-flop synchronizer bringing the far-domain ack toggle into clk.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], xack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // State and every output register; xreq/xdata leave straight from flops.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state   <= IDLE;
            xreq    <= 1'b0;
            xdata   <= '0;
            src_rdy <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            xreq    <= xreq_nxt;
            xdata   <= xdata_nxt;
            src_rdy <= src_rdy_nxt;
            busy    <= busy_nxt;
            err     <= err_nxt;
        end
    end

    // Next-state logic: launch on accept, release once the echoed toggle lands.
    always_comb begin
        state_nxt   = state;
        xreq_nxt    = xreq;
        xdata_nxt   = xdata;
        src_rdy_nxt = src_rdy;
        busy_nxt    = busy;
        err_nxt     = err;
        case (state)
            IDLE: begin
                src_rdy_nxt = 1'b1;
                busy_nxt    = 1'b0;
                // An ack level that disagrees with xreq here has no request behind it.
                if (ack_s != xreq) begin
                    err_nxt = 1'b1;
                end
                if (src_vld && src_rdy) begin
                    xdata_nxt   = src_data;
                    xreq_nxt    = ~xreq;
                    state_nxt   = WAIT;
                    src_rdy_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            WAIT: begin
                src_rdy_nxt = 1'b0;
                busy_nxt    = 1'b1;
                if (ack_s == xreq) begin
                    state_nxt   = IDLE;
                    src_rdy_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_hs_src.sv
// Bench for cdc_hs_src: a far-end responder model scoreboards every launched word
// and echoes the req toggle after a programmable delay.
module tb_cdc_hs_src;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned S     = 2;

    logic             clk = 1'b0;
    logic             clr_ = 1'b0;
    logic             src_vld = 1'b0;
    logic             src_rdy;
    logic [WIDTH-1:0] src_data = '0;
    logic             xreq;
    logic [WIDTH-1:0] xdata;
    logic             xack = 1'b0;
    logic             busy;
    logic             err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             m_req    = 1'b0;
    bit               auto_ack = 1'b1;
    logic             man_ack  = 1'b0;
    int               ack_dly  = 4;

    cdc_hs_src #(.WIDTH(WIDTH), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .clr_     (clr_),
        .src_vld  (src_vld),
        .src_rdy  (src_rdy),
        .src_data (src_data),
        .xreq     (xreq),
        .xdata    (xdata),
        .xack     (xack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Far-end model: samples xdata on each req toggle, holds checks, echoes ack.
    logic             last_req = 1'b0;
    logic             prev_rdy = 1'b0;
    bit               pend     = 1'b0;
    bit               track    = 1'b0;
    int               cnt      = 0;
    int               ack_cyc  = 0;
    logic [WIDTH-1:0] held     = '0;
    logic [WIDTH-1:0] w;

    always @(negedge clk) begin
        if (!clr_) begin
            last_req = 1'b0;
            prev_rdy = 1'b0;
            pend     = 1'b0;
            track    = 1'b0;
            xack     = 1'b0;
        end else begin
            if (src_rdy && !prev_rdy && track) begin
                chk("rdy_latency", 64'(cyc - ack_cyc), 64'(S + 1));
                track = 1'b0;
            end
            prev_rdy = src_rdy;
            if (!auto_ack) xack = man_ack;
            if (xreq != last_req) begin
                last_req = xreq;
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 64'(1), 64'(0));
                end else begin
                    w = exp_q.pop_front();
                    chk("xdata_word", 64'(xdata), 64'(w));
                end
                held = xdata;
                pend = 1'b1;
                cnt  = ack_dly;
            end else if (pend) begin
                chk("hold_wait", 64'({busy, src_rdy, xdata}), 64'({1'b1, 1'b0, held}));
                cnt--;
            end
            if (pend && cnt <= 0) begin
                pend = 1'b0;
                if (auto_ack && xack != xreq) begin
                    xack    = xreq;
                    ack_cyc = cyc;
                    track   = 1'b1;
                end
            end
        end
    end

    // Offer one word; src_data is scrambled while the block is not ready.
    task automatic send(input logic [WIDTH-1:0] d, input bit keep);
        int guard = 0;
        src_vld = 1'b1;
        while (!src_rdy) begin
            src_data = $urandom;
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                chk("rdy_timeout", 64'(0), 64'(1));
                src_vld = 1'b0;
                return;
            end
        end
        src_data = d;
        exp_q.push_back(d);
        m_req = ~m_req;
        @(posedge clk); #1;
        src_vld = keep;
        if (keep) src_data = $urandom;
        chk("accept", 64'({xreq, busy, src_rdy}), 64'({m_req, 1'b1, 1'b0}));
        chk("xdata_accept", 64'(xdata), 64'(d));
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!src_rdy) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                chk("idle_timeout", 64'(0), 64'(1));
                return;
            end
        end
    endtask

    initial begin
        // Reset hold and release.
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_state", 64'({xreq, busy, err, src_rdy, xdata}), 64'(0));
        end
        clr_ = 1'b1;
        chk("rdy_before_edge", 64'(src_rdy), 64'(0));
        @(posedge clk); #1;
        chk("rdy_after_release", 64'({src_rdy, err, busy}), 64'(3'b100));

        // Single transfer, ack four cycles after xreq rises.
        ack_dly = 4;
        send(32'hA5A5_0001, 1'b0);
        wait_idle();

        // Back-to-back words with src_vld held high.
        ack_dly = 3;
        send(32'd1, 1'b1);
        send(32'd2, 1'b1);
        send(32'd3, 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_drained", 64'(exp_q.size()), 64'(0));

        // Spurious ack while idle.
        chk("spur_pre_req", 64'(xreq), 64'(m_req));
        man_ack  = ~m_req;
        auto_ack = 1'b0;
        @(negedge clk); #1;
        for (int k = 0; k < int'(S); k++) begin
            @(posedge clk); #1;
            chk("err_early", 64'(err), 64'(0));
        end
        @(posedge clk); #1;
        chk("err_set", 64'({err, src_rdy, busy}), 64'(3'b110));
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(err), 64'(1));
        auto_ack = 1'b1;
        ack_dly  = 0;
        send($urandom, 1'b0);
        wait_idle();
        chk("err_after_xfer", 64'({err, busy}), 64'(2'b10));

        // Reset mid-transfer with xreq high.
        ack_dly = 1;
        if (m_req) begin
            send($urandom, 1'b0);
            wait_idle();
        end
        ack_dly = 20;
        send(32'hDEAD_BEEF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 64'({busy, xreq}), 64'(2'b11));
        clr_ = 1'b0;
        #1;
        chk("mid_rst_async", 64'({xreq, busy, src_rdy, err, xdata}), 64'(0));
        m_req = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        clr_    = 1'b1;
        ack_dly = 2;
        send(32'h0000_C0DE, 1'b0);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            bit keep;
            ack_dly = $urandom_range(0, 5);
            keep    = (i < 39) && ($urandom_range(0, 1) == 1);
            send($urandom, keep);
            if (!keep) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        src_vld = 1'b0;
        wait_idle();
        repeat (8) @(posedge clk);
        #1;
        chk("final_drained", 64'(exp_q.size()), 64'(0));
        chk("final_state", 64'({err, busy, src_rdy, xreq}), 64'({1'b0, 1'b0, 1'b1, m_req}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
